mod_counter: RTL

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/mod_counter.sv | 89 ++++++++
 1 files changed

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo-(MAX+1) counter with synchronous load, terminal-count flag and wrap pulse.
// Optional saturate mode (extra sat port after d) is compiled in when COUNTER_SAT_EN is defined.
module mod_counter #(
    parameter int unsigned     WIDTH = 4,
    parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
`ifdef COUNTER_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("mod_counter: WIDTH must be within 1..32");
        end
        if (MAX >= (64'd1 << WIDTH)) begin : g_bad_max
            $error("mod_counter: MAX must be below 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] L_MAX = MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_sat;

`ifdef COUNTER_SAT_EN
    assign w_sat = sat;
`else
    assign w_sat = 1'b0;
`endif

    assign w_at_max  = (r_q == L_MAX);
    assign w_at_zero = (r_q == '0);

    // Terminal boundaries are compared explicitly, so q+1 / q-1 never leave 0..MAX.
    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        if (ld) begin
            w_q_next = (d > L_MAX) ? L_MAX : d;
        end else if (en) begin
            if (up) begin
                if (!w_at_max) begin
                    w_q_next = r_q + L_ONE;
                end else if (!w_sat) begin
                    w_q_next    = '0;
                    w_wrap_next = 1'b1;
                end
            end else begin
                if (!w_at_zero) begin
                    w_q_next = r_q - L_ONE;
                end else if (!w_sat) begin
                    w_q_next    = L_MAX;
                    w_wrap_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;
    assign tc   = en & ((up & w_at_max) | (~up & w_at_zero));

endmodule
